// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg
// Shared segment-code type and active-low {g,f,e,d,c,b,a} patterns for the
// BCD 7-segment display path.
package bcd_disp_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'h40;
    localparam seg_t SEG_1     = 7'h79;
    localparam seg_t SEG_2     = 7'h24;
    localparam seg_t SEG_3     = 7'h30;
    localparam seg_t SEG_4     = 7'h19;
    localparam seg_t SEG_5     = 7'h12;
    localparam seg_t SEG_6     = 7'h02;
    localparam seg_t SEG_7     = 7'h78;
    localparam seg_t SEG_8     = 7'h00;
    localparam seg_t SEG_9     = 7'h10;
    localparam seg_t SEG_DASH  = 7'h3F;
    localparam seg_t SEG_BLANK = 7'h7F;

endpackage

// File: rtl/bcd_to_seg.sv
// bcd_to_seg
// Combinational BCD nibble to active-low 7-segment decoder.
// Nibbles A-F show a dash; i_blank forces all segments off.
// Ports:
//   i_nib   [3:0]  BCD digit
//   i_blank        1 = drive all segments off
//   o_seg   [6:0]  segments {g,f,e,d,c,b,a}, active-low
module bcd_to_seg
    import bcd_disp_pkg::*;
(
    input  logic [3:0] i_nib,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        if (i_blank) begin
            o_seg = SEG_BLANK;
        end else begin
            case (i_nib)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/bcd_7seg_scan.sv
// bcd_7seg_scan
// Latches a packed BCD value on a load strobe and time-multiplexes its digits
// onto one common-anode 7-segment bus. The displayed value only changes at
// frame boundaries so one scan never mixes old and new digits.
// Optional build macro BCD7SEG_LZ_BLANK_EN: blank leading zero digits
// (digit 0 is never blanked; an invalid nibble stops blanking).
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   bdc         packed BCD input, [3:0] = least-significant digit
//   load        capture bdc into the pending register
//   pending     a captured value awaits frame transfer
//   an          anode enables, active-low, one-hot-low
//   seg         segments {g,f,e,d,c,b,a}, active-low
//   frame_tick  one-cycle pulse at each frame start
module bcd_7seg_scan
    import bcd_disp_pkg::*;
#(
    parameter int DIGITS   = 3,
    parameter int SCAN_DIV = 50000
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   bdc,
    input  logic                  load,
    output logic                  pending,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  frame_tick
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BW = 4 * DIGITS;

    logic [PW-1:0]     r_presc;
    logic [IW-1:0]     r_idx;
    logic [BW-1:0]     r_disp;
    logic [BW-1:0]     r_pend_val;

    logic              w_tick;
    logic              w_wrap;
    logic [3:0]        w_nib;
    logic              w_blank;
    logic [DIGITS-1:0] w_an;
    logic [DIGITS-1:0] w_lz;
    logic              w_run;
    seg_t              w_seg;

    assign w_tick = (r_presc == PW'(SCAN_DIV - 1));
    assign w_wrap = w_tick && (r_idx == IW'(DIGITS - 1));

    // Leading-zero mask: w_run stays set while every digit from the MSD down
    // to the current one is a valid zero.
    always_comb begin
        w_lz  = '0;
        w_run = 1'b1;
`ifdef BCD7SEG_LZ_BLANK_EN
        for (int unsigned i = DIGITS - 1; i > 0; i--) begin
            w_run   = w_run && (r_disp[4*i +: 4] == 4'd0);
            w_lz[i] = w_run;
        end
`endif
    end

    // Select the nibble, blank flag and anode for the current slot.
    always_comb begin
        w_nib   = '0;
        w_blank = 1'b0;
        w_an    = '1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (r_idx == IW'(i)) begin
                w_nib   = r_disp[4*i +: 4];
                w_blank = w_lz[i];
                w_an[i] = 1'b0;
            end
        end
    end

    bcd_to_seg u_dec (
        .i_nib   (w_nib),
        .i_blank (w_blank),
        .o_seg   (w_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc    <= '0;
            r_idx      <= '0;
            r_disp     <= '0;
            r_pend_val <= '0;
            pending    <= 1'b0;
            frame_tick <= 1'b0;
            an         <= '1;
            seg        <= SEG_BLANK;
        end else begin
            r_presc    <= w_tick ? '0 : r_presc + PW'(1);
            frame_tick <= 1'b0;
            if (w_tick) begin
                r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
            end
            if (w_wrap) begin
                frame_tick <= 1'b1;
                if (pending) begin
                    r_disp  <= r_pend_val;
                    pending <= 1'b0;
                end
            end
            // Placed after the transfer so a coinciding load keeps pending set
            // while the transfer still takes the pre-edge r_pend_val.
            if (load) begin
                r_pend_val <= bdc;
                pending    <= 1'b1;
            end
            an  <= w_an;
            seg <= w_seg;
        end
    end

endmodule

// File: tb/tb_bcd_7seg_scan.sv
module tb_bcd_7seg_scan;

    logic        clk;
    logic        rst;
    logic [11:0] bdc;
    logic        load;
    logic        pending;
    logic [2:0]  an;
    logic [6:0]  seg;
    logic        frame_tick;

    int vectors;
    int miscompares;

    bcd_7seg_scan #(
        .DIGITS   (3),
        .SCAN_DIV (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bdc        (bdc),
        .load       (load),
        .pending    (pending),
        .an         (an),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance to the cycle right after the next frame wrap edge.
    task automatic wait_frame(input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (frame_tick === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, "_frame_seen"}, {11'd0, got}, 12'd1);
    endtask

    // Called just after a wrap edge; checks one full 12-cycle frame and
    // ends just after the following wrap edge.
    task automatic show_frame(input string tag, input logic [6:0] s0,
                              input logic [6:0] s1, input logic [6:0] s2);
        logic [6:0] es;
        logic [2:0] ea;
        int slot;
        for (int c = 1; c <= 12; c++) begin
            step();
            slot = (c - 1) / 4;
            case (slot)
                0:       begin ea = 3'b110; es = s0; end
                1:       begin ea = 3'b101; es = s1; end
                default: begin ea = 3'b011; es = s2; end
            endcase
            chk({tag, "_an"},  {9'd0, an},  {9'd0, ea});
            chk({tag, "_seg"}, {5'd0, seg}, {5'd0, es});
            chk({tag, "_ftick"}, {11'd0, frame_tick}, {11'd0, (c == 12)});
        end
    endtask

    // Load one value right away, then check it across the next frame.
    task automatic load_and_show(input string tag, input logic [11:0] val,
                                 input logic [6:0] s0, input logic [6:0] s1,
                                 input logic [6:0] s2);
        bdc  = val;
        load = 1'b1;
        step();
        load = 1'b0;
        chk({tag, "_pend_set"}, {11'd0, pending}, 12'd1);
        wait_frame(tag);
        chk({tag, "_pend_clr"}, {11'd0, pending}, 12'd0);
        show_frame(tag, s0, s1, s2);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst  = 1'b1;
        load = 1'b0;
        bdc  = 12'h000;

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an",    {9'd0, an},  12'h007);
        chk("rst_seg",   {5'd0, seg}, 12'h07F);
        chk("rst_pend",  {11'd0, pending}, 12'd0);
        chk("rst_ftick", {11'd0, frame_tick}, 12'd0);
        rst = 1'b0;

        // First cycle after release shows digit 0 of zero
        step();
        chk("post_rst_an",  {9'd0, an},  12'h006);
        chk("post_rst_seg", {5'd0, seg}, 12'h040);

        // Single load of 255
        load_and_show("v255", 12'h255, 7'h12, 7'h12, 7'h24);

        // Two loads before the wrap: last one wins
        bdc  = 12'h128;
        load = 1'b1;
        step();
        bdc  = 12'h093;
        step();
        load = 1'b0;
        chk("v093_pend", {11'd0, pending}, 12'd1);
        wait_frame("v093");
`ifdef BCD7SEG_LZ_BLANK_EN
        show_frame("v093", 7'h30, 7'h10, 7'h7F);
`else
        show_frame("v093", 7'h30, 7'h10, 7'h40);
`endif

        // Load on the exact wrap edge: 001 transfers, 042 stays pending
        bdc  = 12'h001;
        load = 1'b1;
        step();
        load = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        bdc  = 12'h042;
        load = 1'b1;
        step();
        load = 1'b0;
        chk("wrapload_ftick", {11'd0, frame_tick}, 12'd1);
        chk("wrapload_pend",  {11'd0, pending}, 12'd1);
`ifdef BCD7SEG_LZ_BLANK_EN
        show_frame("v001", 7'h79, 7'h7F, 7'h7F);
        chk("v042_pend_clr", {11'd0, pending}, 12'd0);
        show_frame("v042", 7'h24, 7'h19, 7'h7F);
`else
        show_frame("v001", 7'h79, 7'h40, 7'h40);
        chk("v042_pend_clr", {11'd0, pending}, 12'd0);
        show_frame("v042", 7'h24, 7'h19, 7'h40);
`endif

        // Zero-heavy values and an invalid MSD nibble
`ifdef BCD7SEG_LZ_BLANK_EN
        load_and_show("v007", 12'h007, 7'h78, 7'h7F, 7'h7F);
        load_and_show("v000", 12'h000, 7'h40, 7'h7F, 7'h7F);
`else
        load_and_show("v007", 12'h007, 7'h78, 7'h40, 7'h40);
        load_and_show("v000", 12'h000, 7'h40, 7'h40, 7'h40);
`endif
        load_and_show("vA07", 12'hA07, 7'h78, 7'h40, 7'h3F);

        // Reset mid-frame with a pending value
        bdc  = 12'h999;
        load = 1'b1;
        step();
        load = 1'b0;
        chk("midrst_pend_before", {11'd0, pending}, 12'd1);
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("midrst_an",    {9'd0, an},  12'h007);
        chk("midrst_seg",   {5'd0, seg}, 12'h07F);
        chk("midrst_pend",  {11'd0, pending}, 12'd0);
        chk("midrst_ftick", {11'd0, frame_tick}, 12'd0);
        rst = 1'b0;
        step();
        chk("midrst_rel_an",  {9'd0, an},  12'h006);
        chk("midrst_rel_seg", {5'd0, seg}, 12'h040);
        wait_frame("midrst");
        chk("midrst_pend_after", {11'd0, pending}, 12'd0);
`ifdef BCD7SEG_LZ_BLANK_EN
        show_frame("midrst_zero", 7'h40, 7'h7F, 7'h7F);
`else
        show_frame("midrst_zero", 7'h40, 7'h40, 7'h40);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
